seq_arith_unit: RTL and testbench

Parametrised multi-cycle arithmetic unit: add, subtract, true multiply and true divide on `W`-bit operands, with a 2W-bit result and a carry/flag bit. It supersedes the fixed 4-bit combinational unit, where "multiply" and "divide" were only ×2/÷2 shifts. Multiply and divide are iterative (shift-add, restoring divide) behind a start/busy/done handshake. It sits between operand/switch registers and the result display/register path.

---
 rtl/arith_pkg.sv | 16 +
 rtl/muldiv_step.sv | 33 +++
 rtl/seq_arith_unit.sv | 130 +++++++++++++
 tb/tb_seq_arith_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit:
// opcode encodings and controller state type.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply
// or restoring divide over a 2W-bit accumulator.
module muldiv_step #(
  parameter int W = 4
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           div_mode,
  output logic [2*W-1:0] acc_next
);

  logic [W:0] sum;
  logic [W:0] shl;
  logic [W:0] trial;

  always_comb begin
    sum   = {1'b0, acc[2*W-1:W]}
          + (acc[0] ? {1'b0, operand} : '0);
    shl   = acc[2*W-1:W-1];
    trial = shl - {1'b0, operand};
    acc_next = '0;
    if (div_mode) begin
      // borrow out of the trial subtract means restore
      if (trial[W])
        acc_next = {shl[W-1:0], acc[W-2:0], 1'b0};
      else
        acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle add/sub/mul/div unit with start/busy/done
// handshake and a held 2W-bit result plus flag.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     sw,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] f,
  output logic           cout
);

  localparam int CW = $clog2(W + 1);

  state_t         st;
  state_t         st_nxt;
  logic [1:0]     op;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  n_iter;
  logic           accept;
  logic           last;
  logic           dz;
  logic [W:0]     add_sum;
  logic [W:0]     sub_dif;
  logic [2*W-1:0] res;
  logic           res_c;

  assign accept = start && (st != ST_RUN);
  assign last   = (cnt == CW'(1));
  assign dz     = (op == OP_DIV) && (opb == '0);

  // counter is loaded with the step count and counts down
  assign n_iter =
    (sw == OP_MUL || (sw == OP_DIV && b != '0))
      ? CW'(W) : CW'(1);

  assign add_sum = {1'b0, opa} + {1'b0, opb};
  assign sub_dif = {1'b0, opa} - {1'b0, opb};

  muldiv_step #(.W(W)) u_step (
    .acc      (acc),
    .operand  (opb),
    .div_mode (op == OP_DIV),
    .acc_next (acc_nxt)
  );

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    unique case (op)
      OP_ADD: begin
        res   = {{(W-1){1'b0}}, add_sum};
        res_c = add_sum[W];
      end
      OP_SUB: begin
        res   = {{W{1'b0}}, sub_dif[W-1:0]};
        res_c = sub_dif[W];
      end
      OP_MUL: begin
        res   = acc_nxt;
        res_c = |acc_nxt[2*W-1:W];
      end
      OP_DIV: begin
        if (dz) begin
          res   = {opa, {W{1'b1}}};
          res_c = 1'b1;
        end else begin
          res   = acc_nxt;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_IDLE: if (start) st_nxt = ST_RUN;
      ST_RUN:  if (last)  st_nxt = ST_DONE;
      ST_DONE: st_nxt = start ? ST_RUN : ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (st == ST_RUN);
    done = (st == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op   <= '0;
      opa  <= '0;
      opb  <= '0;
      acc  <= '0;
      cnt  <= '0;
      f    <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      op  <= sw;
      opa <= a;
      opb <= b;
      acc <= {{W{1'b0}}, a};
      cnt <= n_iter;
    end else if (st == ST_RUN) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      if (last) begin
        f    <= res;
        cout <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed vector table, hand sequences for abort and
// ignored start, and a back-to-back random run vs model.
module tb_seq_arith_unit;
  import arith_pkg::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     sw;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] f;
  logic           cout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] s;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] ef;
    logic       ec;
    int         lat;
  } vec_t;

  vec_t tv[12];

  seq_arith_unit #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sw    (sw),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .f     (f),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [8:0] model(
    input logic [1:0] s, input logic [3:0] x,
    input logic [3:0] y);
    int p;
    logic [8:0] r;
    r = '0;
    case (s)
      OP_ADD: r = {1'b0, 8'(x + y)} | ((x + y > 15) ? 9'h100 : 9'h0);
      OP_SUB: r = {(x < y), 4'h0, 4'(x - y)};
      OP_MUL: begin
        p = x * y;
        r = {(p > 15), 8'(p)};
      end
      default: begin
        if (y == 0) r = {1'b1, x, 4'hF};
        else r = {1'b0, 4'(x % y), 4'(x / y)};
      end
    endcase
    return r;
  endfunction

  // Caller sits at a negedge; inputs apply for the next edge.
  task automatic run(input logic [1:0] s,
                     input logic [3:0] x,
                     input logic [3:0] y,
                     input bit hold,
                     input logic [7:0] ef,
                     input logic ec,
                     input int lat,
                     input string tag);
    int c;
    bit busy_ok;
    start = 1'b1;
    sw = s;
    a = x;
    b = y;
    @(negedge clk);
    c = 0;
    busy_ok = 1'b1;
    if (!hold) start = 1'b0;
    while (!done && c < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      c++;
    end
    chk({tag, " latency"}, c, lat);
    chk({tag, " busy"}, {busy_ok, busy}, 2'b10);
    chk({tag, " f"}, f, ef);
    chk({tag, " cout"}, cout, ec);
  endtask

  initial begin
    int c;
    bit no_done;
    logic [8:0] m;
    logic [1:0] rs;
    logic [3:0] ra;
    logic [3:0] rb;

    tv[0]  = '{OP_ADD, 4'd9,  4'd8,  8'h11, 1'b1, 1};
    tv[1]  = '{OP_ADD, 4'd3,  4'd4,  8'h07, 1'b0, 1};
    tv[2]  = '{OP_ADD, 4'd15, 4'd15, 8'h1E, 1'b1, 1};
    tv[3]  = '{OP_SUB, 4'd3,  4'd5,  8'h0E, 1'b1, 1};
    tv[4]  = '{OP_SUB, 4'd5,  4'd3,  8'h02, 1'b0, 1};
    tv[5]  = '{OP_MUL, 4'd15, 4'd15, 8'hE1, 1'b1, 4};
    tv[6]  = '{OP_MUL, 4'd3,  4'd5,  8'h0F, 1'b0, 4};
    tv[7]  = '{OP_MUL, 4'd0,  4'd9,  8'h00, 1'b0, 4};
    tv[8]  = '{OP_DIV, 4'd13, 4'd4,  8'h13, 1'b0, 4};
    tv[9]  = '{OP_DIV, 4'd7,  4'd0,  8'h7F, 1'b1, 1};
    tv[10] = '{OP_DIV, 4'd2,  4'd7,  8'h20, 1'b0, 4};
    tv[11] = '{OP_DIV, 4'd15, 4'd1,  8'h0F, 1'b0, 4};

    rst = 1'b1;
    start = 1'b0;
    sw = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset f", f, 8'h00);
    chk("reset cout", cout, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tv[i]) begin
      run(tv[i].s, tv[i].x, tv[i].y, 1'b0, tv[i].ef,
          tv[i].ec, tv[i].lat, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // start in RUN and operand changes must be ignored
    start = 1'b1;
    sw = OP_MUL;
    a = 4'd3;
    b = 4'd5;
    @(negedge clk);
    c = 0;
    sw = OP_ADD;
    a = 4'd1;
    b = 4'd1;
    @(negedge clk);
    c++;
    start = 1'b0;
    sw = OP_SUB;
    a = 4'd0;
    b = 4'd0;
    while (!done && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("ignore latency", c, 4);
    chk("ignore f", f, 8'h0F);
    chk("ignore cout", cout, 1'b0);
    @(negedge clk);

    // mid-run reset aborts 15x15 with no done pulse
    no_done = 1'b1;
    start = 1'b1;
    sw = OP_MUL;
    a = 4'd15;
    b = 4'd15;
    @(negedge clk);
    if (done) no_done = 1'b0;
    sw = OP_ADD;
    a = 4'd1;
    b = 4'd1;
    @(negedge clk);
    if (done) no_done = 1'b0;
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort f", f, 8'h00);
    chk("abort cout", cout, 1'b0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    chk("abort no done", no_done, 1'b1);

    // back-to-back with start held high
    for (int i = 0; i < 1000; i++) begin
      rs = 2'(i % 4);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if (i % 16 == 3) rb = 4'd0;
      m = model(rs, ra, rb);
      run(rs, ra, rb, 1'b1, m[7:0], m[8],
          (rs == OP_MUL || (rs == OP_DIV && rb != 0))
            ? 4 : 1,
          $sformatf("b2b%0d", i));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
